// File: rtl/cla_multiword_seq.sv
// Multi-precision add/sub sequencer: NWORDS*WIDTH-bit operands pass word-serially through one CLA_adder.
// Optional build macro CLA_SEQ_SAT_EN: saturate the result on signed overflow.

module CLA_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_overflow
);
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH:0]   w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_c[0] = i_cin;
      for (int i = 0; i < WIDTH; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end

   assign o_sum      = w_p ^ w_c[WIDTH-1:0];
   assign o_cout     = w_c[WIDTH];
   assign o_overflow = ~(i_a[WIDTH-1] ^ i_b[WIDTH-1]) & (i_a[WIDTH-1] ^ o_sum[WIDTH-1]);
endmodule

// state  | meaning
// IDLE   | in_ready high, waiting for an operand pair
// RUN    | one word per cycle through the adder, LS word first
// DONE   | result valid, held until out_ready
module cla_multiword_seq #(
   parameter int WIDTH  = 32,
   parameter int NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NWORDS*WIDTH-1:0]  op_a,
   input  logic [NWORDS*WIDTH-1:0]  op_b,
   input  logic                     cin,
   input  logic                     sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NWORDS*WIDTH-1:0]  sum,
   output logic                     cout,
   output logic                     overflow
);
   localparam int TOTAL = NWORDS * WIDTH;
   localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [TOTAL-1:0]   r_a;
   logic [TOTAL-1:0]   r_b;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [TOTAL-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_a_word;
   logic [WIDTH-1:0]   w_b_word;
   logic [WIDTH-1:0]   w_sum_word;
   logic               w_cout;
   logic               w_ovf;
   logic               w_last;
   logic [TOTAL-1:0]   w_sum_next;
   logic [TOTAL-1:0]   w_sum_fin;

   always_comb begin
      w_a_word   = '0;
      w_b_word   = '0;
      w_sum_next = r_sum;
      for (int i = 0; i < NWORDS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_a_word = r_a[i*WIDTH +: WIDTH];
            w_b_word = r_b[i*WIDTH +: WIDTH];
            w_sum_next[i*WIDTH +: WIDTH] = w_sum_word;
         end
      end
   end

   CLA_adder #(.WIDTH(WIDTH)) u_cla (
      .i_a        (w_a_word),
      .i_b        (w_b_word),
      .i_cin      (r_carry),
      .o_sum      (w_sum_word),
      .o_cout     (w_cout),
      .o_overflow (w_ovf)
   );

   assign w_last = (r_idx == IDX_W'(NWORDS-1));

`ifdef CLA_SEQ_SAT_EN
   // Positive operand overflows to max positive, negative to min negative.
   always_comb begin
      w_sum_fin = w_sum_next;
      if (w_ovf) begin
         w_sum_fin = {r_a[TOTAL-1], {(TOTAL-1){~r_a[TOTAL-1]}}};
      end
   end
`else
   assign w_sum_fin = w_sum_next;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_RUN;
         S_RUN:   if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= sub ? ~op_b : op_b;
                  r_carry <= sub ? 1'b1 : cin;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_carry <= w_cout;
               if (w_last) begin
                  r_sum  <= w_sum_fin;
                  r_cout <= w_cout;
                  r_ovf  <= w_ovf;
                  r_idx  <= '0;
               end else begin
                  r_sum  <= w_sum_next;
                  r_idx  <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign overflow  = r_ovf;
endmodule
